// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the five-stage RISC-V pipeline.
//
// Owns the program counter, issues word reads to instruction memory over a
// req/valid handshake and presents fetched words to ID through an IF/ID
// output register backed by a one-entry skid buffer. Honours stalls from ID
// and branch/jump redirects from EX (redirect wins over stall and transfer).
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   imem_req / imem_addr  read request and byte address (address == PC)
//   imem_rdata/imem_valid read data and response strobe
//   id_stall              ID cannot accept; output register holds
//   redirect/redirect_pc  taken branch/jump target from EX; flushes IF/ID
//   instr_valid/instruction/PC_n  IF/ID output register
//   fetch_count           accepted-instruction counter (FETCH_PERF_CNT_EN only)
//
// Build option: define FETCH_PERF_CNT_EN to add the fetch_count port/counter.

module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        id_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] PC_n
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_HOLD,
        ST_DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic xfer;
    logic accept;
    logic out_hold;
    logic to_skid;

    // Request is a pure function of state so reset drops it asynchronously.
    assign imem_req    = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign imem_addr   = pc_q;
    assign instr_valid = out_valid_q;
    assign instruction = out_instr_q;
    assign PC_n        = out_pc_q;

    assign xfer     = imem_req && imem_valid;
    // Only a FETCH-state transfer without redirect delivers a usable word.
    assign accept   = (state_q == ST_FETCH) && xfer && !redirect;
    assign out_hold = id_stall && out_valid_q;
    // Skid is only ever filled from FETCH, and FETCH never runs with the
    // skid full (a fill moves to HOLD), so ordering is preserved.
    assign to_skid  = accept && out_hold;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        // IF/ID output register and skid
        if (redirect) begin
            out_valid_d  = 1'b0;
            out_instr_d  = NOP_INSTR;
            skid_valid_d = 1'b0;
        end else begin
            if (!out_hold) begin
                if (skid_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_instr_d  = skid_instr_q;
                    out_pc_d     = skid_pc_q;
                    skid_valid_d = 1'b0;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    out_instr_d = imem_rdata;
                    out_pc_d    = pc_q;
                end else begin
                    out_valid_d = 1'b0;
                    out_instr_d = NOP_INSTR;
                end
            end
            if (to_skid) begin
                skid_valid_d = 1'b1;
                skid_instr_d = imem_rdata;
                skid_pc_d    = pc_q;
            end
        end

        // PC / state sequencing
        case (state_q)
            ST_BOOT: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (xfer) begin
                    if (redirect) begin
                        pc_d = redirect_pc;
                    end else begin
                        pc_d = pc_q + 32'd4;
                        if (to_skid) begin
                            state_d = ST_HOLD;
                        end
                    end
                end else if (redirect) begin
                    // Request must complete at the old address first.
                    tgt_d   = redirect_pc;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (redirect) begin
                    tgt_d = redirect_pc;
                end
                if (xfer) begin
                    pc_d    = redirect ? redirect_pc : tgt_q;
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = ST_FETCH;
                end else if (!id_stall) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            tgt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_instr_q  <= NOP_INSTR;
            out_pc_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            tgt_q        <= tgt_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (out_valid_q && !id_stall && !redirect) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign fetch_count = count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
// Instruction memory is a ROM with a programmable response latency: a
// request completes once it has been held for 'lat' extra cycles
// (lat=0 answers combinationally in the first cycle).

module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        id_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] PC_n;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    int total;
    int bad;
    int unsigned lat;
    int unsigned wait_cnt;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .id_stall   (id_stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instruction(instruction),
        .PC_n       (PC_n)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count(fetch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0:   rom = 32'h0050_0113;
            32'h4:   rom = 32'h00A0_0193;
            32'h8:   rom = 32'h0000_2223;
            default: rom = 32'hC000_0000 | a;
        endcase
    endfunction

    assign imem_rdata = rom(imem_addr);
    assign imem_valid = imem_req && (wait_cnt >= lat);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 0;
        end else if (imem_req && !imem_valid) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total       = 0;
        bad         = 0;
        lat         = 0;
        reset       = 1'b1;
        id_stall    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        tick(2);

        // reset state
        check("rst_req",   imem_req,    32'd0);
        check("rst_valid", instr_valid, 32'd0);
        check("rst_instr", instruction, 32'h13);
        check("rst_pcn",   PC_n,        32'h0);
        check("rst_addr",  imem_addr,   32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_cnt",   fetch_count, 32'h0);
`endif
        reset = 1'b0;              // cycle 0: BOOT
        check("boot_req", imem_req, 32'd0);
        tick(1);                   // cycle 1: FETCH PC 0
        check("c1_req",   imem_req,    32'd1);
        check("c1_addr",  imem_addr,   32'h0);
        check("c1_valid", instr_valid, 32'd0);
        tick(1);                   // cycle 2
        check("c2_valid", instr_valid, 32'd1);
        check("c2_instr", instruction, 32'h0050_0113);
        check("c2_pcn",   PC_n,        32'h0);
        tick(1);                   // cycle 3
        check("c3_instr", instruction, 32'h00A0_0193);
        check("c3_pcn",   PC_n,        32'h4);

        // stall 4 cycles with PC 4 on the output; PC 8 goes to skid
        id_stall = 1'b1;
        tick(1);                   // cycle 4
        check("st4_instr", instruction, 32'h00A0_0193);
        check("st4_pcn",   PC_n,        32'h4);
        check("st4_req",   imem_req,    32'd0);
        tick(2);                   // cycle 6
        check("st6_pcn",   PC_n,        32'h4);
        check("st6_valid", instr_valid, 32'd1);
        check("st6_req",   imem_req,    32'd0);
        tick(1);                   // cycle 7
        id_stall = 1'b0;
        tick(1);                   // cycle 8
        check("rel8_instr", instruction, 32'h0000_2223);
        check("rel8_pcn",   PC_n,        32'h8);
        tick(1);                   // cycle 9
        check("rel9_instr", instruction, 32'hC000_000C);
        check("rel9_pcn",   PC_n,        32'hC);

        // fill output (PC 12) and skid (PC 16), then redirect to 0x40
        id_stall = 1'b1;
        tick(1);                   // cycle 10
        check("fill_pcn", PC_n,     32'hC);
        check("fill_req", imem_req, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick(1);                   // cycle 11
        check("flush_valid", instr_valid, 32'd0);
        check("flush_instr", instruction, 32'h13);
        check("flush_addr",  imem_addr,   32'h40);
        check("flush_req",   imem_req,    32'd1);
        redirect = 1'b0;
        id_stall = 1'b0;
        tick(1);                   // cycle 12
        check("tgt_valid", instr_valid, 32'd1);
        check("tgt_pcn",   PC_n,        32'h40);
        check("tgt_instr", instruction, 32'hC000_0040);

        // 3-cycle memory: a word every 3 cycles, bubbles in between
        lat = 2;
        tick(1);                   // cycle 13
        check("l13_valid", instr_valid, 32'd0);
        check("l13_addr",  imem_addr,   32'h44);
        check("l13_req",   imem_req,    32'd1);
        tick(1);                   // cycle 14
        check("l14_addr",  imem_addr,   32'h44);
        check("l14_valid", instr_valid, 32'd0);
        tick(1);                   // cycle 15
        check("l15_pcn",   PC_n,        32'h44);
        check("l15_valid", instr_valid, 32'd1);
        tick(1);                   // cycle 16
        check("l16_valid", instr_valid, 32'd0);
        check("l16_addr",  imem_addr,   32'h48);
        tick(2);                   // cycle 18
        check("l18_pcn",   PC_n,        32'h48);

        // redirect while waiting at 0x4C -> DRAIN, then FETCH 0x10
        redirect    = 1'b1;
        redirect_pc = 32'h10;
        tick(1);                   // cycle 19
        check("dr19_addr",  imem_addr,   32'h4C);
        check("dr19_req",   imem_req,    32'd1);
        check("dr19_valid", instr_valid, 32'd0);
        redirect = 1'b0;
        tick(1);                   // cycle 20
        check("dr20_addr",  imem_addr,   32'h4C);
        tick(1);                   // cycle 21
        check("dr21_addr",  imem_addr,   32'h10);
        check("dr21_valid", instr_valid, 32'd0);

        // redirect during wait at 0x10, then a second redirect in DRAIN
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        tick(1);                   // cycle 22
        check("dd22_addr", imem_addr, 32'h10);
        redirect_pc = 32'hC0;
        tick(1);                   // cycle 23
        redirect = 1'b0;
        tick(1);                   // cycle 24
        check("dd24_addr",  imem_addr,   32'hC0);
        check("dd24_valid", instr_valid, 32'd0);
        tick(2);                   // cycle 26
        check("dd26_valid", instr_valid, 32'd0);
        tick(1);                   // cycle 27
        check("dd27_pcn",   PC_n,        32'hC0);
        check("dd27_instr", instruction, 32'hC000_00C0);

        // hold output valid, then reset in the middle of a wait
        id_stall = 1'b1;
        tick(1);                   // cycle 28
        check("pre_valid", instr_valid, 32'd1);
        check("pre_req",   imem_req,    32'd1);
        check("pre_addr",  imem_addr,   32'hC4);
`ifdef FETCH_PERF_CNT_EN
        check("pre_cnt",   fetch_count, 32'd5);
`endif
        #1 reset = 1'b1;
        #1;
        check("ar_req",   imem_req,    32'd0);
        check("ar_valid", instr_valid, 32'd0);
        check("ar_instr", instruction, 32'h13);
        check("ar_addr",  imem_addr,   32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("ar_cnt",   fetch_count, 32'd0);
`endif
        tick(1);
        reset    = 1'b0;
        id_stall = 1'b0;
        lat      = 0;
        check("rb_req", imem_req, 32'd0);
        tick(1);
        check("rf_req",  imem_req,  32'd1);
        check("rf_addr", imem_addr, 32'h0);
        tick(1);
        check("rf_instr", instruction, 32'h0050_0113);
        check("rf_pcn",   PC_n,        32'h0);
        tick(1);
        check("rf_pcn2",  PC_n,        32'h4);
`ifdef FETCH_PERF_CNT_EN
        check("rf_cnt",   fetch_count, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage RISC-V pipeline, directly upstream of the decoder and ID/EX register. It owns the program counter and issues word reads to instruction memory over a req/valid handshake. It presents `instruction` and `PC_n` to ID through an IF/ID output register backed by a one-entry skid buffer. It honours stalls from ID and branch/jump redirects from EX.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset
- `NOP_INSTR`, 32'h0000_0013, value of `instruction` when empty, at reset and after a flush (addi x0,x0,0)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `imem_req`  out  1  read request to instruction memory
- `imem_addr`  out  32  byte address of the request; always equals the PC register
- `imem_rdata`  in  32  read data, valid when `imem_valid`=1
- `imem_valid`  in  1  response; a transfer occurs on a cycle with `imem_req`=1 and `imem_valid`=1
- `id_stall`  in  1  ID cannot accept; hold the current output
- `redirect`  in  1  taken branch/jump from EX; flush and refetch
- `redirect_pc`  in  32  target, sampled when `redirect`=1
- `instr_valid`  out  1  `instruction` / `PC_n` hold a real fetched instruction
- `instruction`  out  32  to decoder
- `PC_n`  out  32  address of `instruction`, to ID/EX
- `fetch_count`  out  32  present only with `FETCH_PERF_CNT_EN`

## Operation
- Registers:
  - PC
  - FSM state: BOOT, FETCH, HOLD, DRAIN
  - output register: `instr_valid`/`instruction`/`PC_n`
  - skid register: valid/instr/pc
  - pending target (32b)
- Memory rule: once `imem_req` rises, it stays high with stable `imem_addr` until a transfer. Memory may answer in the same cycle (combinational) or any later cycle.
- BOOT: `imem_req`=0; go to FETCH next cycle. Entered only from reset.
- FETCH: `imem_req`=1.
  - Transfer with no redirect: PC += 4 (mod 2^32). The word goes to the output register if it is empty or `id_stall`=0; otherwise it goes to the skid. If the skid is now full, go to HOLD, else stay.
  - Transfer with `redirect`: discard the word, PC <= `redirect_pc`, stay in FETCH.
  - No transfer with `redirect`: latch the target, go to DRAIN.
- DRAIN: `imem_req`=1 at the old address.
  - On transfer: discard, PC <= latched target, go to FETCH.
  - A new `redirect` in DRAIN overwrites the latched target.
- HOLD: `imem_req`=0.
  - When `id_stall`=0: skid moves to the output register; go to FETCH next cycle.
  - `redirect` in HOLD: PC <= `redirect_pc`, go to FETCH.
- Output register:
  - If `id_stall`=1 and it is valid, it holds.
  - Otherwise it loads from the skid if the skid is full, else from the current transfer, else becomes empty (`instruction`=`NOP_INSTR`).
- Flush: `redirect` clears output and skid valids at the same edge, so `instruction`=`NOP_INSTR` next cycle. Redirect has priority over `id_stall` and over any transfer in that cycle.
- Order is preserved: an instruction never bypasses the skid.

## Timing
- Reset values:
  - PC=`RESET_PC`, state=BOOT, `imem_req`=0
  - `instr_valid`=0, `instruction`=`NOP_INSTR`, `PC_n`=0
  - skid empty, `fetch_count`=0
- Reset asserted mid-transaction: the outstanding request is abandoned and `imem_req` drops asynchronously.
- Latency, zero-wait memory:
  - cycle 0 after reset release = BOOT
  - cycle 1 = FETCH, transfer of `RESET_PC`
  - `instr_valid`=1 with `PC_n`=`RESET_PC` from cycle 2
- Throughput with zero-wait memory: 1 instruction/cycle.
- Redirect penalty, zero-wait memory: the cycle after `redirect` issues `redirect_pc`; the target reaches the output one cycle later.
- Stall: with skid and output both full, `imem_req`=0; no word is ever lost or duplicated.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `fetch_count` exists.
  - It increments on every cycle with `instr_valid`=1 and `id_stall`=0 and `redirect`=0.
  - Wraps at 2^32; reset to 0.
- Not defined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Zero-wait ROM, `RESET_PC`=0, words 0x00500113, 0x00A00193, 0x00002223 -> `instruction` shows them on cycles 2,3,4 with `PC_n`=0,4,8.
- 3-cycle memory latency -> `imem_addr` is stable while `imem_req`=1; a new instruction appears every 3 cycles; `instr_valid` drops between them.
- `id_stall`=1 for 4 cycles starting with `PC_n`=4 on the output -> output holds 0x00A00193/4, the skid holds PC 8, `imem_req`=0. After release, PCs 8 and 12 follow on consecutive cycles.
- `redirect`=1, `redirect_pc`=0x40, while output (PC 8) and skid are full -> next cycle `instr_valid`=0 and `instruction`=0x00000013; the next valid `PC_n` is 0x40.
- `redirect` during a 3-cycle memory wait at PC 0x10 -> DRAIN; the 0x10 word is discarded; the next `imem_addr` is the target. A second redirect during DRAIN wins.
- Reset asserted mid-wait with `FETCH_PERF_CNT_EN` defined and `fetch_count`=5 -> `imem_req`=0, `fetch_count`=0 and `instr_valid`=0 immediately; fetch restarts at `RESET_PC`.
